// File: rtl/sr_reg_bank.sv
// Bank of WIDTH independent SR latches with a configurable both-asserted policy,
// sticky collision flags and a saturating collision counter. Macro SR_FILTER_EN adds input debounce.
module sr_reg_bank #(
   parameter int WIDTH    = 8,
   parameter int MODE     = 0,
   parameter int CNT_W    = 8,
   parameter int FILT_CYC = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] set,
   input  logic [WIDTH-1:0] reset,
   input  logic             clr_err,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic [WIDTH-1:0] both_err,
   output logic [CNT_W-1:0] err_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("sr_reg_bank: WIDTH out of range");
   end
   if (MODE < 0 || MODE > 3) begin : g_bad_mode
      $error("sr_reg_bank: MODE out of range");
   end
   if (CNT_W < 2 || CNT_W > 16) begin : g_bad_cnt_w
      $error("sr_reg_bank: CNT_W out of range");
   end
   if (FILT_CYC < 1 || FILT_CYC > 15) begin : g_bad_filt
      $error("sr_reg_bank: FILT_CYC out of range");
   end

   logic [WIDTH-1:0] es;
   logic [WIDTH-1:0] er;

`ifdef SR_FILTER_EN
   localparam logic [3:0] FILT_MAX = 4'(FILT_CYC);
   localparam logic [3:0] FILT_THR = 4'(FILT_CYC - 1);

   logic [3:0] set_cnt_q [WIDTH];
   logic [3:0] set_cnt_d [WIDTH];
   logic [3:0] rst_cnt_q [WIDTH];
   logic [3:0] rst_cnt_d [WIDTH];

   // A request passes on the edge that completes FILT_CYC consecutive high samples.
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         set_cnt_d[i] = '0;
         rst_cnt_d[i] = '0;
         if (set[i]) set_cnt_d[i] = (set_cnt_q[i] < FILT_MAX) ? set_cnt_q[i] + 4'd1 : set_cnt_q[i];
         if (reset[i]) rst_cnt_d[i] = (rst_cnt_q[i] < FILT_MAX) ? rst_cnt_q[i] + 4'd1 : rst_cnt_q[i];
         es[i] = set[i] && (set_cnt_q[i] >= FILT_THR);
         er[i] = reset[i] && (rst_cnt_q[i] >= FILT_THR);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < WIDTH; i++) begin
            set_cnt_q[i] <= '0;
            rst_cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            set_cnt_q[i] <= set_cnt_d[i];
            rst_cnt_q[i] <= rst_cnt_d[i];
         end
      end
   end
`else
   assign es = set;
   assign er = reset;
`endif

   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] both_err_q, both_err_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [WIDTH-1:0] ev;
   logic             any_ev;

   assign ev     = es & er;
   assign any_ev = |ev;

   always_comb begin
      q_d = q_q;
      for (int i = 0; i < WIDTH; i++) begin
         case ({es[i], er[i]})
            2'b10:   q_d[i] = 1'b1;
            2'b01:   q_d[i] = 1'b0;
            2'b11: begin
               case (MODE)
                  0:       q_d[i] = 1'b0;
                  1:       q_d[i] = 1'b1;
                  3:       q_d[i] = ~q_q[i];
                  default: q_d[i] = q_q[i];
               endcase
            end
            default: q_d[i] = q_q[i];
         endcase
      end
   end

   // A collision on the same edge as clr_err survives the clear.
   always_comb begin
      both_err_d = clr_err ? ev : (both_err_q | ev);
      err_cnt_d  = clr_err ? '0 : err_cnt_q;
      if (any_ev) begin
         if (clr_err)                    err_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
         else if (err_cnt_q != CNT_MAX)  err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q        <= '0;
         both_err_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         q_q        <= q_d;
         both_err_q <= both_err_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign q        = q_q;
   assign qbar     = ~q_q;
   assign both_err = both_err_q;
   assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_sr_reg_bank.sv
// Directed bench for sr_reg_bank: one instance per MODE plus a CNT_W=2 instance,
// all driven by the same inputs. Filter scenarios compile in with SR_FILTER_EN.
module tb_sr_reg_bank;

   logic       clk;
   logic       rst_n;
   logic [7:0] set;
   logic [7:0] reset;
   logic       clr_err;

   logic [7:0] q0, qb0, be0; logic [7:0] ec0;
   logic [7:0] q1, qb1, be1; logic [7:0] ec1;
   logic [7:0] q2, qb2, be2; logic [7:0] ec2;
   logic [7:0] q3, qb3, be3; logic [7:0] ec3;
   logic [7:0] qs, qbs, bes; logic [1:0] ecs;

   int n_checks = 0;
   int n_errors = 0;

   sr_reg_bank #(.WIDTH(8), .MODE(0), .CNT_W(8)) u_m0 (.clk(clk), .rst_n(rst_n), .set(set), .reset(reset),
      .clr_err(clr_err), .q(q0), .qbar(qb0), .both_err(be0), .err_cnt(ec0));
   sr_reg_bank #(.WIDTH(8), .MODE(1), .CNT_W(8)) u_m1 (.clk(clk), .rst_n(rst_n), .set(set), .reset(reset),
      .clr_err(clr_err), .q(q1), .qbar(qb1), .both_err(be1), .err_cnt(ec1));
   sr_reg_bank #(.WIDTH(8), .MODE(2), .CNT_W(8)) u_m2 (.clk(clk), .rst_n(rst_n), .set(set), .reset(reset),
      .clr_err(clr_err), .q(q2), .qbar(qb2), .both_err(be2), .err_cnt(ec2));
   sr_reg_bank #(.WIDTH(8), .MODE(3), .CNT_W(8)) u_m3 (.clk(clk), .rst_n(rst_n), .set(set), .reset(reset),
      .clr_err(clr_err), .q(q3), .qbar(qb3), .both_err(be3), .err_cnt(ec3));
   sr_reg_bank #(.WIDTH(8), .MODE(0), .CNT_W(2)) u_sat (.clk(clk), .rst_n(rst_n), .set(set), .reset(reset),
      .clr_err(clr_err), .q(qs), .qbar(qbs), .both_err(bes), .err_cnt(ecs));

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #2;
      n_checks++; if (q0 !== 8'h00) begin n_errors++; $display("FAIL reset_q: got %h exp 00", q0); end
      n_checks++; if (qb0 !== 8'hFF) begin n_errors++; $display("FAIL reset_qbar: got %h exp FF", qb0); end
      n_checks++; if (ec0 !== 8'd0) begin n_errors++; $display("FAIL reset_cnt: got %0d exp 0", ec0); end
      n_checks++; if (be0 !== 8'h00) begin n_errors++; $display("FAIL reset_both_err: got %h exp 00", be0); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      set = 8'h0F; step();
      n_checks++; if (q0 !== 8'h0F) begin n_errors++; $display("FAIL basic_set: got %h exp 0F", q0); end
      set = 8'h00; reset = 8'h03; step();
      n_checks++; if (q0 !== 8'h0C) begin n_errors++; $display("FAIL basic_reset: got %h exp 0C", q0); end
      n_checks++; if (qb0 !== 8'hF3) begin n_errors++; $display("FAIL basic_qbar: got %h exp F3", qb0); end
      n_checks++; if (be0 !== 8'h00) begin n_errors++; $display("FAIL basic_both_err: got %h exp 00", be0); end
      reset = 8'h00; step();
      n_checks++; if (q0 !== 8'h0C) begin n_errors++; $display("FAIL basic_hold: got %h exp 0C", q0); end
      set = 8'h80; step();
      n_checks++; if (q0 !== 8'h8C) begin n_errors++; $display("FAIL independence: got %h exp 8C", q0); end
      set = 8'h00;
   endtask

   task automatic test_mode_sweep();
      pulse_reset();
      set = 8'h01; step();
      n_checks++; if ({q3[0], q2[0], q1[0], q0[0]} !== 4'b1111) begin n_errors++;
         $display("FAIL mode_preset: got %b exp 1111", {q3[0], q2[0], q1[0], q0[0]}); end
      reset = 8'h01; step();
      n_checks++; if ({q3[0], q2[0], q1[0], q0[0]} !== 4'b0110) begin n_errors++;
         $display("FAIL mode_edge1: got %b exp 0110", {q3[0], q2[0], q1[0], q0[0]}); end
      step();
      n_checks++; if ({q3[0], q2[0], q1[0], q0[0]} !== 4'b1110) begin n_errors++;
         $display("FAIL mode_edge2: got %b exp 1110", {q3[0], q2[0], q1[0], q0[0]}); end
      n_checks++; if ({be3[0], be2[0], be1[0], be0[0]} !== 4'b1111) begin n_errors++;
         $display("FAIL mode_both_err: got %b exp 1111", {be3[0], be2[0], be1[0], be0[0]}); end
      n_checks++; if ({ec3, ec2, ec1, ec0} !== {8'd2, 8'd2, 8'd2, 8'd2}) begin n_errors++;
         $display("FAIL mode_cnt: got %0d %0d %0d %0d exp 2 each", ec0, ec1, ec2, ec3); end
   endtask

   task automatic test_all_channels();
      set = 8'hFF; reset = 8'hFF; step();
      n_checks++; if ({q3, q2, q1, q0} !== {8'hFE, 8'h01, 8'hFF, 8'h00}) begin n_errors++;
         $display("FAIL all_q: got %h %h %h %h exp 00 FF 01 FE", q0, q1, q2, q3); end
      n_checks++; if (ec0 !== 8'd3) begin n_errors++; $display("FAIL all_cnt_once: got %0d exp 3", ec0); end
      n_checks++; if (be0 !== 8'hFF) begin n_errors++; $display("FAIL all_both_err: got %h exp FF", be0); end
      n_checks++; if (qb3 !== 8'h01) begin n_errors++; $display("FAIL all_qbar: got %h exp 01", qb3); end
   endtask

   task automatic test_clear();
      set = 8'h00; reset = 8'h00; clr_err = 1'b1; step();
      n_checks++; if (ec0 !== 8'd0) begin n_errors++; $display("FAIL clr_cnt: got %0d exp 0", ec0); end
      n_checks++; if (be0 !== 8'h00) begin n_errors++; $display("FAIL clr_both_err: got %h exp 00", be0); end
      n_checks++; if (q1 !== 8'hFF) begin n_errors++; $display("FAIL clr_keeps_q: got %h exp FF", q1); end
      set = 8'h10; reset = 8'h10; step();
      n_checks++; if (be0 !== 8'h10) begin n_errors++; $display("FAIL clr_race_flag: got %h exp 10", be0); end
      n_checks++; if (ec0 !== 8'd1) begin n_errors++; $display("FAIL clr_race_cnt: got %0d exp 1", ec0); end
      clr_err = 1'b0; set = 8'h00; reset = 8'h00;
   endtask

   task automatic test_saturation();
      logic [1:0] exp_sat;
      pulse_reset();
      set = 8'h01; reset = 8'h01;
      for (int k = 0; k < 5; k++) begin
         step();
         exp_sat = (k >= 2) ? 2'd3 : 2'(k + 1);
         n_checks++; if (ecs !== exp_sat) begin n_errors++;
            $display("FAIL sat_cnt[%0d]: got %0d exp %0d", k, ecs, exp_sat); end
      end
      n_checks++; if (ec0 !== 8'd5) begin n_errors++; $display("FAIL wide_cnt: got %0d exp 5", ec0); end
      set = 8'h00; reset = 8'h00; step();
      n_checks++; if (ecs !== 2'd3) begin n_errors++; $display("FAIL sat_hold: got %0d exp 3", ecs); end
      clr_err = 1'b1; set = 8'h01; reset = 8'h01; step();
      n_checks++; if (ecs !== 2'd1) begin n_errors++; $display("FAIL sat_clr_race: got %0d exp 1", ecs); end
      clr_err = 1'b0; set = 8'h00; reset = 8'h00;
   endtask

   task automatic test_reset_mid_op();
      set = 8'hF0; step();
      n_checks++; if (q1 !== 8'hF1) begin n_errors++; $display("FAIL midop_pre: got %h exp F1", q1); end
      set = 8'h00;
      rst_n = 1'b0; #1;
      n_checks++; if (q1 !== 8'h00) begin n_errors++; $display("FAIL midop_q: got %h exp 00", q1); end
      n_checks++; if (qb3 !== 8'hFF) begin n_errors++; $display("FAIL midop_qbar: got %h exp FF", qb3); end
      n_checks++; if (be1 !== 8'h00 || ec1 !== 8'd0) begin n_errors++;
         $display("FAIL midop_err: got %h/%0d exp 00/0", be1, ec1); end
      rst_n = 1'b1;
      set = 8'h02; step();
      n_checks++; if (q1 !== 8'h02) begin n_errors++; $display("FAIL first_edge: got %h exp 02", q1); end
      set = 8'h00;
   endtask

   task automatic test_filter();
`ifdef SR_FILTER_EN
      pulse_reset();
      set = 8'h04; step(); step();
      n_checks++; if (q0[2] !== 1'b0) begin n_errors++; $display("FAIL filt_short: got %b exp 0", q0[2]); end
      set = 8'h00; step();
      set = 8'h04; step(); step();
      n_checks++; if (q0[2] !== 1'b0) begin n_errors++; $display("FAIL filt_restart: got %b exp 0", q0[2]); end
      step();
      n_checks++; if (q0[2] !== 1'b1) begin n_errors++; $display("FAIL filt_pass: got %b exp 1", q0[2]); end
      pulse_reset();
      set = 8'h02; step(); step();
      pulse_reset();
      step(); step();
      n_checks++; if (q0[1] !== 1'b0) begin n_errors++; $display("FAIL filt_rst_discard: got %b exp 0", q0[1]); end
      step();
      n_checks++; if (q0[1] !== 1'b1) begin n_errors++; $display("FAIL filt_rst_pass: got %b exp 1", q0[1]); end
      set = 8'h00;
`endif
   endtask

   initial begin
      rst_n = 1'b0; set = 8'h00; reset = 8'h00; clr_err = 1'b0;
      test_reset();
      test_basic();
      test_mode_sweep();
      test_all_channels();
      test_clear();
      test_saturation();
      test_reset_mid_op();
      test_filter();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sr_reg_bank.md
SR_REG_BANK -- requirements
Module: sr_reg_bank

Interface
REQ-001 Parameter WIDTH, default 8: number of independent SR channels, legal range 1..32.
REQ-002 Parameter MODE, default 0: behaviour when set and reset are both asserted. 0 = reset-dominant, 1 = set-dominant, 2 = hold, 3 = toggle.
REQ-003 Parameter CNT_W, default 8: width of the error-event counter, legal range 2..16.
REQ-004 Parameter FILT_CYC, default 3: debounce length in cycles, legal range 1..15; used only when the filter is compiled in.
REQ-005 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 Port set, input, WIDTH: per-channel set request, active-high, sampled on clk.
REQ-008 Port reset, input, WIDTH: per-channel reset request, active-high, sampled on clk.
REQ-009 Port clr_err, input, 1: synchronous clear of both_err and err_cnt.
REQ-010 Port q, output, WIDTH: registered latch state per channel.
REQ-011 Port qbar, output, WIDTH: complement of q.
REQ-012 Port both_err, output, WIDTH: sticky per-channel flag recording a simultaneous set and reset.
REQ-013 Port err_cnt, output, CNT_W: saturating count of cycles in which any channel had a simultaneous set and reset.

Function
REQ-014 Each channel's effective requests are es and er: the raw inputs, or the filtered inputs when the filter is compiled in.
REQ-015 Per channel, per clock edge:
- es=1, er=0 -> q=1
- es=0, er=1 -> q=0
- es=0, er=0 -> q holds
- es=1, er=1 -> resolved per MODE (0: q=0; 1: q=1; 2: q holds; 3: q inverts)
REQ-016 Without the filter, q reflects the requests sampled at edge N immediately after edge N (one-edge latency).
REQ-017 qbar SHALL equal ~q at all times, including during reset; q and qbar are never equal.
REQ-018 both_err[i] sets on any edge where es[i]=1 and er[i]=1, and stays set until cleared, in every MODE.
REQ-019 err_cnt increments by 1 per edge where at least one channel has es=1 and er=1, regardless of how many channels do; it saturates at 2^CNT_W-1 and never wraps.
REQ-020 clr_err=1 at an edge zeroes both_err and err_cnt.
REQ-021 If a new simultaneous event occurs on the same edge as clr_err, the event wins: the affected both_err bits end at 1 and err_cnt ends at 1.
REQ-022 Channels are fully independent; activity on one channel never alters the q of another.

Reset
REQ-023 While rst_n=0, regardless of clk: q=0, qbar all ones, both_err=0, err_cnt=0, and all filter counters=0.
REQ-024 Reset asserted mid-operation, including mid-debounce, discards all partial state; after release every channel behaves as freshly reset.
REQ-025 On the first clock edge after rst_n rises, inputs are sampled normally.

Configuration
REQ-026 Macro SR_FILTER_EN. When defined, each set and reset input bit gets its own consecutive-high counter.
- The filtered request is 1 on the edge where the raw input has been sampled high for FILT_CYC consecutive edges, and on every following edge while the input stays high.
- A single low sample clears the counter and the filtered request immediately.
- Counters saturate at FILT_CYC.
- FILT_CYC=1 is cycle-identical to the unfiltered build.
REQ-027 When SR_FILTER_EN is undefined, no filter logic exists, FILT_CYC is ignored, and es/er equal the raw inputs.

Verification
REQ-028 Reset check: rst_n=0 asynchronously between edges -> q=8'h00, qbar=8'hFF, err_cnt=0 with no clock edge required.
REQ-029 Basic set/reset, no filter: set=8'h0F for 1 cycle, then reset=8'h03 for 1 cycle -> q=8'h0F after the first edge, then q=8'h0C; both_err=0 throughout.
REQ-030 MODE sweep: for each MODE 0..3, channel 0 with q=1, then set[0]=reset[0]=1 for 2 edges -> q[0] ends at 0, 1, 1, 1 respectively (MODE 3 toggles 1->0->1); both_err[0]=1; err_cnt=2.
REQ-031 Saturation and clear race: CNT_W=2, simultaneous events on 5 consecutive edges -> err_cnt=3 and holds; then clr_err=1 on the same edge as a new event -> err_cnt=1.
REQ-032 Filter (SR_FILTER_EN, FILT_CYC=3): set[2] high for 2 edges, low for 1 edge, then high for 3 edges -> q[2] stays 0 until the third consecutive high edge, then becomes 1.
REQ-033 Reset mid-debounce (SR_FILTER_EN): set[1] high for 2 edges, rst_n pulsed low, set[1] held high -> q[1] rises only after 3 further edges following reset release.
